test_ram_arbiter: RTL and testbench

//  Two-requester scheduler for the 256x32 simple-dual-port TEST_RAM (single clock domain).

---
 rtl/test_ram_arb_pkg.sv | 19 +
 rtl/test_ram_arbiter_rr_arb2.sv | 27 ++
 rtl/test_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_test_ram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/test_ram_arb_pkg.sv
// Shared types and default widths for the TEST_RAM arbiter.
package test_ram_arb_pkg;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int DATA_W_DEFAULT = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // One slot of the read-response pipeline.
   typedef struct packed {
      logic [1:0]                valid;
      logic                      fwd;
      logic [DATA_W_DEFAULT-1:0] fwd_data;
   } rsp_t;

endpackage

// File: rtl/test_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the other requester after a grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      grant = 2'b00;
      if (en) begin
         if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
         else                grant = valid;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         ptr <= 1'b0;
      else if (|grant) ptr <= grant[0];
   end

endmodule

// File: rtl/test_ram_arbiter.sv
// Write/read port scheduler for the 256x32 TEST_RAM with zero-fill and write-to-read forwarding.
module test_ram_arbiter
   import test_ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic [1:0]        wreq_valid,
   output logic [1:0]        wreq_ready,
   input  logic [2*ADDR_W-1:0] wreq_addr,
   input  logic [2*DATA_W-1:0] wreq_data,
   input  logic [1:0]        rreq_valid,
   output logic [1:0]        rreq_ready,
   input  logic [2*ADDR_W-1:0] rreq_addr,
   output logic [1:0]        rrsp_valid,
   output logic [DATA_W-1:0] rrsp_data,
   output logic              ram_wr_en,
   output logic              ram_wr_clk_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clear_cnt, clear_cnt_nxt;
   logic              run;
   logic              wr_go, rd_go;
   logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   rsp_t              rsp_in;
   rsp_t              pipe [RD_LAT];

   assign run        = (state == RUN);
   assign clear_busy = (state == CLEAR);

   rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .en(run), .valid(wreq_valid), .grant(wreq_ready));
   rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .en(run), .valid(rreq_valid), .grant(rreq_ready));

   assign wr_go = |wreq_ready;
   assign rd_go = |rreq_ready;

   // A clear request in CLEAR restarts the sweep rather than extending it.
   always_comb begin
      state_nxt     = state;
      clear_cnt_nxt = clear_cnt;
      case (state)
         CLEAR: begin
            clear_cnt_nxt = clear_cnt + 1'b1;
            if (clear_req)            clear_cnt_nxt = '0;
            else if (&clear_cnt)      state_nxt     = RUN;
         end
         RUN: begin
            if (clear_req) begin
               state_nxt     = CLEAR;
               clear_cnt_nxt = '0;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         clear_cnt <= '0;
      end else begin
         state     <= state_nxt;
         clear_cnt <= clear_cnt_nxt;
      end
   end

   // Write port: zero-fill in CLEAR, granted requester in RUN, last values held when idle.
   always_comb begin
      ram_wr_en   = 1'b0;
      ram_wr_addr = wr_addr_q;
      ram_wr_data = wr_data_q;
      if (clear_busy) begin
         ram_wr_en   = ~rst;
         ram_wr_addr = clear_cnt;
         ram_wr_data = '0;
      end else if (wr_go) begin
         ram_wr_en   = 1'b1;
         ram_wr_addr = wreq_ready[1] ? wreq_addr[ADDR_W +: ADDR_W] : wreq_addr[0 +: ADDR_W];
         ram_wr_data = wreq_ready[1] ? wreq_data[DATA_W +: DATA_W] : wreq_data[0 +: DATA_W];
      end
   end

   assign ram_wr_clk_en = ram_wr_en;
   assign ram_rd_addr   = rd_go ? (rreq_ready[1] ? rreq_addr[ADDR_W +: ADDR_W]
                                                 : rreq_addr[0 +: ADDR_W])
                                : rd_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
      end else begin
         if (ram_wr_en) begin
            wr_addr_q <= ram_wr_addr;
            wr_data_q <= ram_wr_data;
         end
         rd_addr_q <= ram_rd_addr;
      end
   end

   // Same-cycle collision: the RAM would return pre-write data, so carry the write data along.
   always_comb begin
      rsp_in          = '0;
      rsp_in.valid    = rreq_ready;
      rsp_in.fwd      = rd_go && wr_go && (ram_wr_addr == ram_rd_addr);
      rsp_in.fwd_data = ram_wr_data;
   end

   // NOTE: the response pipeline is a handful of flops and is reset; the RAM array itself is
   // never reset but zero-filled by the CLEAR sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= rsp_in;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign rrsp_valid = pipe[RD_LAT-1].valid;
   assign rrsp_data  = (|pipe[RD_LAT-1].valid)
                       ? (pipe[RD_LAT-1].fwd ? pipe[RD_LAT-1].fwd_data : ram_rd_data)
                       : '0;

endmodule

// File: tb/tb_test_ram_arbiter.sv
// Directed bench for test_ram_arbiter: RAM stand-in, reference memory model and response scoreboard.
module tb_test_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_req;
   logic        clear_busy;
   logic [1:0]  wreq_valid, wreq_ready, rreq_valid, rreq_ready, rrsp_valid;
   logic [15:0] wreq_addr, rreq_addr;
   logic [63:0] wreq_data;
   logic [31:0] rrsp_data, ram_wr_data, ram_rd_data;
   logic        ram_wr_en, ram_wr_clk_en;
   logic [7:0]  ram_wr_addr, ram_rd_addr;

   test_ram_arbiter dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
      .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
      .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
      .rrsp_valid(rrsp_valid), .rrsp_data(rrsp_data),
      .ram_wr_en(ram_wr_en), .ram_wr_clk_en(ram_wr_clk_en), .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   // RAM stand-in: registered read, read-before-write on the same edge, random power-up contents.
   logic [31:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
      ram_rd_data = '0;
   end
   always @(posedge clk) begin
      if (ram_wr_clk_en && ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_rd_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int          due;
      logic [1:0]  onehot;
      logic [31:0] data;
   } sb_t;
   sb_t         sb [$];
   logic [31:0] ref_mem [256];
   logic        m_clear, m_wptr, m_rptr;
   int          m_cnt;
   logic [7:0]  m_last_ra;
   int          rgrant0, rgrant1;

   function automatic logic [1:0] arb(input logic [1:0] v, input logic p);
      if (v == 2'b11) return p ? 2'b10 : 2'b01;
      return v;
   endfunction

   task automatic model_reset();
      m_clear = 1'b1; m_cnt = 0; m_wptr = 1'b0; m_rptr = 1'b0; m_last_ra = '0;
      sb.delete();
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, then advance the model.
   task automatic step(input logic clr, input logic [1:0] wv, input logic [7:0] wa0, input logic [7:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [1:0] rv, input logic [7:0] ra0, input logic [7:0] ra1);
      logic [1:0]  eg_w, eg_r;
      logic [7:0]  wa, ra;
      logic [31:0] wd;
      sb_t         e;
      @(negedge clk);
      clear_req  = clr;
      wreq_valid = wv; wreq_addr = {wa1, wa0}; wreq_data = {wd1, wd0};
      rreq_valid = rv; rreq_addr = {ra1, ra0};
      #1;
      eg_w = m_clear ? 2'b00 : arb(wv, m_wptr);
      eg_r = m_clear ? 2'b00 : arb(rv, m_rptr);
      wa = eg_w[1] ? wa1 : wa0;
      wd = eg_w[1] ? wd1 : wd0;
      ra = eg_r[1] ? ra1 : ra0;
      check("clear_busy", 64'(clear_busy), 64'(m_clear));
      check("wreq_ready", 64'(wreq_ready), 64'(eg_w));
      check("rreq_ready", 64'(rreq_ready), 64'(eg_r));
      if (m_clear) begin
         check("clr_wr_en", 64'({ram_wr_en, ram_wr_clk_en}), 64'(2'b11));
         check("clr_wr_addr", 64'(ram_wr_addr), 64'(m_cnt));
         check("clr_wr_data", 64'(ram_wr_data), 64'(0));
      end else if (eg_w != 2'b00) begin
         check("wr_en", 64'({ram_wr_en, ram_wr_clk_en}), 64'(2'b11));
         check("wr_addr", 64'(ram_wr_addr), 64'(wa));
         check("wr_data", 64'(ram_wr_data), 64'(wd));
      end else begin
         check("wr_idle", 64'({ram_wr_en, ram_wr_clk_en}), 64'(2'b00));
      end
      if (eg_r != 2'b00) begin
         check("rd_addr", 64'(ram_rd_addr), 64'(ra));
         e.due    = cyc + 1;
         e.onehot = eg_r;
         e.data   = (eg_w != 2'b00 && wa == ra) ? wd : ref_mem[ra];
         sb.push_back(e);
         m_rptr    = eg_r[0];
         m_last_ra = ra;
         if (eg_r[0]) rgrant0++; else rgrant1++;
      end else begin
         check("rd_addr_hold", 64'(ram_rd_addr), 64'(m_last_ra));
      end
      if (eg_w != 2'b00) begin
         ref_mem[wa] = wd;
         m_wptr      = eg_w[0];
      end
      if (m_clear) begin
         ref_mem[m_cnt] = '0;
         if (clr)              m_cnt = 0;
         else if (m_cnt == 255) m_clear = 1'b0;
         else                  m_cnt++;
      end else if (clr) begin
         m_clear = 1'b1;
         m_cnt   = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b00, 8'h0, 8'h0);
   endtask

   // Response monitor: pops the scoreboard exactly when a response is due.
   always @(negedge clk) begin
      sb_t e;
      if (!rst) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rsp_valid", 64'(rrsp_valid), 64'(e.onehot));
            check("rsp_data", 64'(rrsp_data), 64'(e.data));
         end else begin
            check("rsp_idle", 64'(rrsp_valid), 64'(0));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(clear_busy), 64'(1));
      check({tag, "_ready"}, 64'({wreq_ready, rreq_ready}), 64'(0));
      check({tag, "_wr"}, 64'({ram_wr_en, ram_wr_clk_en, ram_wr_addr, ram_wr_data}), 64'(0));
      check({tag, "_rd"}, 64'({rrsp_valid, rrsp_data, ram_rd_addr}), 64'(0));
   endtask

   initial begin
      rst = 1'b1; clear_req = 1'b0;
      wreq_valid = 2'b11; wreq_addr = 16'h0201; wreq_data = 64'h5;
      rreq_valid = 2'b11; rreq_addr = 16'h0403;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hFFFF_FFFF;
      rgrant0 = 0; rgrant1 = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");

      // 1: release reset; zero-fill sweep with requests held, then read 0x7F
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 256; i++) step(1'b0, 2'b11, 8'h01, 8'h02, 32'h5, 32'h6, 2'b11, 8'h03, 8'h04);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b01, 8'h7F, 8'h0);
      idle(1);

      // 2: both writers every cycle, then read back both addresses
      for (int i = 0; i < 4; i++) step(1'b0, 2'b11, 8'h10, 8'h11, 32'hA0, 32'hB1, 2'b00, 8'h0, 8'h0);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b01, 8'h10, 8'h11);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b10, 8'h10, 8'h11);
      idle(1);

      // 3: both readers continuously for 8 cycles
      rgrant0 = 0; rgrant1 = 0;
      for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b11, 8'h10, 8'h11);
      check("fair_grants0", 64'(rgrant0), 64'(4));
      check("fair_grants1", 64'(rgrant1), 64'(4));
      idle(1);

      // 4: read one cycle before a write, then same-cycle collision
      step(1'b0, 2'b01, 8'h20, 8'h0, 32'h1, 32'h0, 2'b00, 8'h0, 8'h0);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b01, 8'h20, 8'h0);
      step(1'b0, 2'b10, 8'h0, 8'h20, 32'h0, 32'hDEADBEEF, 2'b10, 8'h0, 8'h20);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b01, 8'h20, 8'h0);
      idle(1);

      // 5: clear request while reads are in flight, requests held through the sweep
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b10, 8'h0, 8'h11);
      step(1'b1, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b01, 8'h10, 8'h0);
      for (int i = 0; i < 256; i++) step(1'b0, 2'b11, 8'h30, 8'h31, 32'h7, 32'h8, 2'b11, 8'h10, 8'h20);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b11, 8'h10, 8'h20);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b11, 8'h10, 8'h20);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b01, 8'h11, 8'h0);
      idle(1);

      // 6: push both pointers to 1, start a clear, reset asynchronously at clear cycle 100
      step(1'b0, 2'b01, 8'h40, 8'h0, 32'h44, 32'h0, 2'b01, 8'h40, 8'h0);
      idle(1);
      step(1'b1, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b00, 8'h0, 8'h0);
      for (int i = 0; i < 100; i++) step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b00, 8'h0, 8'h0);
      #1 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 256; i++) step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b00, 8'h0, 8'h0);
      step(1'b0, 2'b11, 8'h50, 8'h51, 32'h55, 32'h66, 2'b11, 8'h40, 8'h50);
      step(1'b0, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b11, 8'h50, 8'h51);
      idle(3);

      check("sb_empty", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
